// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter renderer.
//   anim_state_t    : punch animation states
//   FRAME_*         : anim_frame encodings selecting the sprite ROM frame
//   TRANSPARENT_IDX : palette index treated as the see-through colour key
//   frame_of()      : maps an animation state to its sprite frame
package fighter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WINDUP,
      STRIKE,
      RECOVER
   } anim_state_t;

   localparam logic [1:0] FRAME_IDLE   = 2'd0;
   localparam logic [1:0] FRAME_MID    = 2'd1;
   localparam logic [1:0] FRAME_STRIKE = 2'd2;

   localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

   function automatic logic [1:0] frame_of(anim_state_t s);
      case (s)
         IDLE:    return FRAME_IDLE;
         STRIKE:  return FRAME_STRIKE;
         default: return FRAME_MID;
      endcase
   endfunction

endpackage

// File: rtl/punch_anim_fsm.sv
// Punch animation sequencer: IDLE -> WINDUP -> STRIKE -> RECOVER -> IDLE, advancing
// only on frame_tick so sprite frames change during vblank.
// Ports:
//   Clk, Reset  : pixel clock, synchronous active-high reset
//   frame_tick  : one-cycle pulse per video frame
//   punch_req   : punch request (level or pulse), honoured only in IDLE
//   anim_frame  : registered sprite frame (0 idle, 1 windup/recover, 2 strike)
//   busy        : registered, high whenever not IDLE
module punch_anim_fsm
   import fighter_pkg::*;
#(
   parameter int unsigned HOLD_WINDUP  = 4,
   parameter int unsigned HOLD_STRIKE  = 6,
   parameter int unsigned HOLD_RECOVER = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       punch_req,
   output logic [1:0] anim_frame,
   output logic       busy
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST_WINDUP  = CNT_W'(HOLD_WINDUP - 1);
   localparam logic [CNT_W-1:0] LAST_STRIKE  = CNT_W'(HOLD_STRIKE - 1);
   localparam logic [CNT_W-1:0] LAST_RECOVER = CNT_W'(HOLD_RECOVER - 1);

   anim_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic [1:0]       anim_frame_q;
   logic             busy_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      unique case (state_q)
         IDLE: begin
            // A request in the same cycle as the tick starts immediately.
            if (frame_tick && (pending_q || punch_req)) begin
               state_d   = WINDUP;
               cnt_d     = '0;
               pending_d = 1'b0;
            end else if (punch_req) begin
               pending_d = 1'b1;
            end
         end
         WINDUP: begin
            if (frame_tick) begin
               if (cnt_q == LAST_WINDUP) begin
                  state_d = STRIKE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         STRIKE: begin
            if (frame_tick) begin
               if (cnt_q == LAST_STRIKE) begin
                  state_d = RECOVER;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RECOVER: begin
            if (frame_tick) begin
               if (cnt_q == LAST_RECOVER) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         anim_frame_q <= FRAME_IDLE;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         // Decoded from the next state so outputs move with the state itself.
         anim_frame_q <= frame_of(state_d);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign anim_frame = anim_frame_q;
   assign busy       = busy_q;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite fetch: hit-tests the beam against the fighter box, forms the
// sprite ROM address for the current animation frame (optionally mirrored), and
// returns the palette index three cycles after the beam sample.
// Ports:
//   Clk, Reset              : pixel clock, synchronous active-high reset
//   frame_tick, punch_req   : animation controls (see punch_anim_fsm)
//   facing_left             : mirror sprite horizontally
//   DrawX, DrawY            : beam position
//   SpriteX, SpriteY        : sprite top-left corner
//   rom_addr / rom_q        : registered ROM address, ROM data one cycle later
//   pal_index, pix_valid    : palette index and opacity flag
//   anim_frame, busy        : animation frame and activity
module sprite_pixel_fetch
   import fighter_pkg::*;
#(
   parameter int unsigned SPR_W        = 64,
   parameter int unsigned SPR_H        = 96,
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned HOLD_WINDUP  = 4,
   parameter int unsigned HOLD_STRIKE  = 6,
   parameter int unsigned HOLD_RECOVER = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_tick,
   input  logic              punch_req,
   input  logic              facing_left,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        SpriteX,
   input  logic [9:0]        SpriteY,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pal_index,
   output logic              pix_valid,
   output logic [1:0]        anim_frame,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0] ROW_PIX   = ADDR_W'(SPR_W);
   localparam logic [9:0]        COL_MAX   = 10'(SPR_W - 1);

   logic [10:0]       dx_ext, dy_ext, sx_ext, sy_ext;
   logic              hit;
   logic [9:0]        dx_off, dy_off, col;
   logic [ADDR_W-1:0] addr_c;

   logic [ADDR_W-1:0] rom_addr_q;
   logic [2:0]        hit_pipe_q;
   logic [3:0]        pal_index_q;

   punch_anim_fsm #(
      .HOLD_WINDUP  (HOLD_WINDUP),
      .HOLD_STRIKE  (HOLD_STRIKE),
      .HOLD_RECOVER (HOLD_RECOVER)
   ) u_anim (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .punch_req  (punch_req),
      .anim_frame (anim_frame),
      .busy       (busy)
   );

   // Box test done at 11 bits so a sprite near x=1023 does not wrap to 0.
   always_comb begin
      dx_ext = {1'b0, DrawX};
      dy_ext = {1'b0, DrawY};
      sx_ext = {1'b0, SpriteX};
      sy_ext = {1'b0, SpriteY};
      hit    = (dx_ext >= sx_ext) && (dx_ext < sx_ext + 11'(SPR_W)) &&
               (dy_ext >= sy_ext) && (dy_ext < sy_ext + 11'(SPR_H));
      dx_off = DrawX - SpriteX;
      dy_off = DrawY - SpriteY;
      col    = facing_left ? (COL_MAX - dx_off) : dx_off;
      addr_c = ADDR_W'(anim_frame) * FRAME_PIX + ADDR_W'(dy_off) * ROW_PIX + ADDR_W'(col);
   end

   // hit_pipe_q[1] lines up with rom_q; [2] lines up with pal_index_q.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr_q  <= '0;
         hit_pipe_q  <= '0;
         pal_index_q <= TRANSPARENT_IDX;
      end else begin
         rom_addr_q  <= hit ? addr_c : '0;
         hit_pipe_q  <= {hit_pipe_q[1:0], hit};
         pal_index_q <= hit_pipe_q[1] ? rom_q : TRANSPARENT_IDX;
      end
   end

   assign rom_addr  = rom_addr_q;
   assign pal_index = pal_index_q;
   assign pix_valid = hit_pipe_q[2] && (pal_index_q != TRANSPARENT_IDX);

endmodule
